// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: opcodes, function codes, control enums and the decode bundle.
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {OP1_REG, OP1_IMM, OP1_PC} op1_src_e;
    typedef enum logic [2:0] {OP2_REG, OP2_IMM, OP2_ZERO, OP2_FOUR} op2_src_e;
    typedef enum logic       {PC_OP1_PC, PC_OP1_REG} pc_op1_src_e;
    typedef enum logic [1:0] {
        NPC_ALWAYS_NOT_BRANCH, NPC_ALWAYS_BRANCH, NPC_ZERO, NPC_NOT_ZERO
    } next_pc_src_e;
    typedef enum logic       {WDATA_ALU, WDATA_RAM} wdata_src_e;

    typedef struct packed {
        logic [4:0]   rs1_address;
        logic [4:0]   rs2_address;
        logic [4:0]   rd_address;
        logic [31:0]  imm;
        alu_op_e      alu_op;
        op1_src_e     op1_src;
        op2_src_e     op2_src;
        pc_op1_src_e  pc_op1_src;
        next_pc_src_e next_pc_src;
        wdata_src_e   wdata_src;
        logic         reg_wren;
        logic         ram_wren;
        logic [2:0]   mem_funct3;
        logic         illegal;
    } decode_bundle_t;

    function automatic alu_op_e base_alu_op(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_comb.sv
// Purpose: combinational RV32I(+M) instruction decoder, inst -> decode_bundle_t.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the enclosing stage owns all flow control.
module decode_comb
    import cpu_pkg::*;
#(
    parameter bit ENABLE_M        = 1'b0,
    parameter bit ZERO_RD_NOWRITE = 1'b1
) (
    input  logic [31:0]    inst,
    output decode_bundle_t dec
);

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    logic        legal;

    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_sh = {27'b0, inst[24:20]};

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec.rd_address = inst[11:7];
                dec.imm        = imm_u;
                dec.op1_src    = OP1_IMM;
                dec.op2_src    = OP2_ZERO;
                dec.reg_wren   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.rd_address = inst[11:7];
                dec.imm        = imm_u;
                dec.op1_src    = OP1_PC;
                dec.op2_src    = OP2_IMM;
                dec.reg_wren   = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link value PC+4; the target adder is fed separately.
                dec.rd_address  = inst[11:7];
                dec.op1_src     = OP1_PC;
                dec.op2_src     = OP2_FOUR;
                dec.next_pc_src = NPC_ALWAYS_BRANCH;
                dec.reg_wren    = 1'b1;
                if (opcode == OPC_JAL) begin
                    dec.imm = imm_j;
                end else begin
                    dec.rs1_address = inst[19:15];
                    dec.imm         = imm_i;
                    dec.pc_op1_src  = PC_OP1_REG;
                    legal           = (f3 == 3'b000);
                end
            end
            OPC_BRANCH: begin
                dec.rs1_address = inst[19:15];
                dec.rs2_address = inst[24:20];
                dec.imm         = imm_b;
                case (f3)
                    F3_BEQ:  begin dec.alu_op = ALU_SUB;  dec.next_pc_src = NPC_ZERO;     end
                    F3_BNE:  begin dec.alu_op = ALU_SUB;  dec.next_pc_src = NPC_NOT_ZERO; end
                    F3_BLT:  begin dec.alu_op = ALU_SLT;  dec.next_pc_src = NPC_NOT_ZERO; end
                    F3_BGE:  begin dec.alu_op = ALU_SLT;  dec.next_pc_src = NPC_ZERO;     end
                    F3_BLTU: begin dec.alu_op = ALU_SLTU; dec.next_pc_src = NPC_NOT_ZERO; end
                    F3_BGEU: begin dec.alu_op = ALU_SLTU; dec.next_pc_src = NPC_ZERO;     end
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                dec.rd_address  = inst[11:7];
                dec.rs1_address = inst[19:15];
                dec.imm         = imm_i;
                dec.op2_src     = OP2_IMM;
                dec.wdata_src   = WDATA_RAM;
                dec.reg_wren    = 1'b1;
                dec.mem_funct3  = f3;
                legal           = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            end
            OPC_STORE: begin
                dec.rs1_address = inst[19:15];
                dec.rs2_address = inst[24:20];
                dec.imm         = imm_s;
                dec.op2_src     = OP2_IMM;
                dec.ram_wren    = 1'b1;
                dec.mem_funct3  = f3;
                legal           = (f3 <= 3'b010);
            end
            OPC_OP_IMM: begin
                dec.rd_address  = inst[11:7];
                dec.rs1_address = inst[19:15];
                dec.op2_src     = OP2_IMM;
                dec.reg_wren    = 1'b1;
                if (f3 == F3_SLL || f3 == F3_SRL_SRA) begin
                    dec.imm    = imm_sh;
                    dec.alu_op = base_alu_op(f3, f7[5]);
                    legal      = (f7 == F7_BASE) || (f3 == F3_SRL_SRA && f7 == F7_ALT);
                end else begin
                    dec.imm    = imm_i;
                    dec.alu_op = base_alu_op(f3, 1'b0);
                end
            end
            OPC_OP: begin
                dec.rd_address  = inst[11:7];
                dec.rs1_address = inst[19:15];
                dec.rs2_address = inst[24:20];
                dec.reg_wren    = 1'b1;
                if (f7 == F7_BASE) begin
                    dec.alu_op = base_alu_op(f3, 1'b0);
                end else if (f7 == F7_ALT) begin
                    dec.alu_op = base_alu_op(f3, 1'b1);
                    legal      = (f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA);
                end else if (f7 == F7_MULDIV && ENABLE_M) begin
                    dec.alu_op = alu_op_e'(5'(ALU_MUL) + {2'b00, f3});
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            dec             = '0;
            dec.illegal     = 1'b1;
            dec.next_pc_src = NPC_ALWAYS_NOT_BRANCH;
        end
        if (ZERO_RD_NOWRITE && dec.rd_address == 5'd0) begin
            dec.reg_wren = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Purpose: registered decode stage with valid/ready handshake, one skid entry and flush.
// Latency: 1 cycle from accept to out_valid when downstream is not stalled.
// Backpressure: in_ready is registered and drops once the skid entry holds a bundle.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int XLEN            = 32,
    parameter bit ENABLE_M        = 1'b0,
    parameter bit ZERO_RD_NOWRITE = 1'b1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1_address,
    output logic [4:0]      rs2_address,
    output logic [4:0]      rd_address,
    output logic [31:0]     imm,
    output logic [4:0]      alu_rd_operator,
    output logic [1:0]      alu_rd_operand1_src,
    output logic [2:0]      alu_rd_operand2_src,
    output logic            alu_pc_operand1_src,
    output logic [1:0]      next_pc_src,
    output logic            reg_write_data_src,
    output logic            reg_wren,
    output logic            ram_wren,
    output logic [2:0]      mem_funct3,
    output logic            illegal
);

    if (XLEN != 32) begin : g_bad_xlen
        $error("decode_stage supports only XLEN=32");
    end

    typedef struct packed {
        logic [XLEN-1:0] pc;
        decode_bundle_t  dec;
    } entry_t;

    decode_bundle_t dec_new;
    entry_t         new_entry, out_q, skid_q;
    logic           accept;

    decode_comb #(.ENABLE_M(ENABLE_M), .ZERO_RD_NOWRITE(ZERO_RD_NOWRITE)) u_decode_comb (
        .inst (in_inst),
        .dec  (dec_new)
    );

    assign new_entry = '{pc: in_pc, dec: dec_new};
    assign accept    = in_valid & in_ready;

    // in_ready low means the skid entry is occupied, which implies out_valid is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_q     <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (!in_ready) begin
            if (out_ready) begin
                out_q    <= skid_q;
                in_ready <= 1'b1;
            end
        end else if (!out_valid || out_ready) begin
            out_valid <= accept;
            if (accept) begin
                out_q <= new_entry;
            end
        end else if (accept) begin
            skid_q   <= new_entry;
            in_ready <= 1'b0;
        end
    end

    assign out_pc              = out_q.pc;
    assign rs1_address         = out_q.dec.rs1_address;
    assign rs2_address         = out_q.dec.rs2_address;
    assign rd_address          = out_q.dec.rd_address;
    assign imm                 = out_q.dec.imm;
    assign alu_rd_operator     = out_q.dec.alu_op;
    assign alu_rd_operand1_src = out_q.dec.op1_src;
    assign alu_rd_operand2_src = out_q.dec.op2_src;
    assign alu_pc_operand1_src = out_q.dec.pc_op1_src;
    assign next_pc_src         = out_q.dec.next_pc_src;
    assign reg_write_data_src  = out_q.dec.wdata_src;
    assign reg_wren            = out_q.dec.reg_wren;
    assign ram_wren            = out_q.dec.ram_wren;
    assign mem_funct3          = out_q.dec.mem_funct3;
    assign illegal             = out_q.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps then random traffic, with ENABLE_M=0 and =1 instances side by side.
module tb_decode_stage;
    import cpu_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [4:0]  op;
        logic [1:0]  o1;
        logic [2:0]  o2;
        logic        po1;
        logic [1:0]  npc;
        logic        ws, rw, mw;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } txn_t;

    localparam logic [4:0] BASE_TAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                            ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    localparam logic [4:0] MUL_TAB  [8] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                                            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    localparam logic [6:0] OPC_TAB  [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                            7'h03, 7'h23, 7'h13, 7'h33};
    localparam logic [6:0] F7_TAB   [3] = '{7'h00, 7'h20, 7'h01};

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, out_ready;
    logic [31:0] in_inst, in_pc;

    logic        in_ready0, out_valid0, po1_0, ws0, rw0, mw0, ill0;
    logic [31:0] pc0, imm0;
    logic [4:0]  rs1_0, rs2_0, rd0, op0;
    logic [1:0]  o1_0, npc0;
    logic [2:0]  o2_0, f3_0;
    logic        in_ready1, out_valid1, po1_1, ws1, rw1, mw1, ill1;
    logic [31:0] pc1, imm1;
    logic [4:0]  rs1_1, rs2_1, rd1, op1;
    logic [1:0]  o1_1, npc1;
    logic [2:0]  o2_1, f3_1;

    exp_t obs0, obs1;
    assign obs0 = {pc0, rs1_0, rs2_0, rd0, imm0, op0, o1_0, o2_0, po1_0, npc0, ws0, rw0, mw0, f3_0, ill0};
    assign obs1 = {pc1, rs1_1, rs2_1, rd1, imm1, op1, o1_1, o2_1, po1_1, npc1, ws1, rw1, mw1, f3_1, ill1};

    decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .ZERO_RD_NOWRITE(1'b1)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid0), .out_ready(out_ready),
        .out_pc(pc0), .rs1_address(rs1_0), .rs2_address(rs2_0), .rd_address(rd0), .imm(imm0),
        .alu_rd_operator(op0), .alu_rd_operand1_src(o1_0), .alu_rd_operand2_src(o2_0),
        .alu_pc_operand1_src(po1_0), .next_pc_src(npc0), .reg_write_data_src(ws0),
        .reg_wren(rw0), .ram_wren(mw0), .mem_funct3(f3_0), .illegal(ill0)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .ZERO_RD_NOWRITE(1'b1)) dut_m (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid1), .out_ready(out_ready),
        .out_pc(pc1), .rs1_address(rs1_1), .rs2_address(rs2_1), .rd_address(rd1), .imm(imm1),
        .alu_rd_operator(op1), .alu_rd_operand1_src(o1_1), .alu_rd_operand2_src(o2_1),
        .alu_pc_operand1_src(po1_1), .next_pc_src(npc1), .reg_write_data_src(ws1),
        .reg_wren(rw1), .ram_wren(mw1), .mem_funct3(f3_1), .illegal(ill1)
    );

    always #5 clk = ~clk;

    int   passes = 0;
    int   total  = 0;
    txn_t q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] simm12(input logic [11:0] v);
        return 32'(int'(v) - (v[11] ? 4096 : 0));
    endfunction

    // Reference decode written from the ISA rules, one mnemonic group at a time.
    function automatic exp_t ref_dec(input logic [31:0] i, input logic [31:0] pc, input bit en_m);
        exp_t e;
        bit   ok;
        int   f3, f7, v;
        e = '0; e.pc = pc; ok = 1'b1;
        f3 = int'(i[14:12]);
        f7 = int'(i[31:25]);
        case (i[6:0])
            7'h37, 7'h17: begin
                e.rd = i[11:7]; e.imm = i & 32'hFFFFF000; e.rw = 1'b1;
                e.o1 = (i[6:0] == 7'h37) ? OP1_IMM : OP1_PC;
                e.o2 = (i[6:0] == 7'h37) ? OP2_ZERO : OP2_IMM;
            end
            7'h6F: begin
                v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096 - (i[31] ? 1048576 : 0);
                e.rd = i[11:7]; e.imm = 32'(v); e.o1 = OP1_PC; e.o2 = OP2_FOUR;
                e.npc = NPC_ALWAYS_BRANCH; e.rw = 1'b1;
            end
            7'h67: begin
                ok = (f3 == 0);
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = simm12(i[31:20]);
                e.o1 = OP1_PC; e.o2 = OP2_FOUR; e.po1 = PC_OP1_REG;
                e.npc = NPC_ALWAYS_BRANCH; e.rw = 1'b1;
            end
            7'h63: begin
                v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048 - (i[31] ? 4096 : 0);
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = 32'(v);
                case (f3)
                    0: begin e.op = ALU_SUB;  e.npc = NPC_ZERO;     end // beq: a-b == 0
                    1: begin e.op = ALU_SUB;  e.npc = NPC_NOT_ZERO; end
                    4: begin e.op = ALU_SLT;  e.npc = NPC_NOT_ZERO; end // blt: slt == 1
                    5: begin e.op = ALU_SLT;  e.npc = NPC_ZERO;     end
                    6: begin e.op = ALU_SLTU; e.npc = NPC_NOT_ZERO; end
                    7: begin e.op = ALU_SLTU; e.npc = NPC_ZERO;     end
                    default: ok = 1'b0;
                endcase
            end
            7'h03: begin
                ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.imm = simm12(i[31:20]);
                e.o2 = OP2_IMM; e.ws = WDATA_RAM; e.rw = 1'b1; e.f3 = i[14:12];
            end
            7'h23: begin
                ok = (f3 <= 2);
                e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.imm = simm12({i[31:25], i[11:7]});
                e.o2 = OP2_IMM; e.mw = 1'b1; e.f3 = i[14:12];
            end
            7'h13: begin
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.o2 = OP2_IMM; e.rw = 1'b1;
                if (f3 == 1) begin
                    ok = (f7 == 0); e.op = ALU_SLL; e.imm = 32'(i[24:20]);
                end else if (f3 == 5) begin
                    ok = (f7 == 0) || (f7 == 32); e.op = (f7 == 32) ? ALU_SRA : ALU_SRL;
                    e.imm = 32'(i[24:20]);
                end else begin
                    e.op = BASE_TAB[f3]; e.imm = simm12(i[31:20]);
                end
            end
            7'h33: begin
                e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rw = 1'b1; e.o2 = OP2_REG;
                if (f7 == 0)       e.op = BASE_TAB[f3];
                else if (f7 == 1) begin ok = en_m; e.op = MUL_TAB[f3]; end
                else if (f7 == 32) begin
                    ok = (f3 == 0) || (f3 == 5); e.op = (f3 == 0) ? ALU_SUB : ALU_SRA;
                end else ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '0; e.pc = pc; e.ill = 1'b1; e.npc = NPC_ALWAYS_NOT_BRANCH;
        end
        if (e.rd == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = int'($urandom_range(0, 9));
        if (k < 9) r[6:0] = OPC_TAB[k];
        if ((r[6:0] == 7'h33 || r[6:0] == 7'h13) && $urandom_range(0, 1) == 1)
            r[31:25] = F7_TAB[$urandom_range(0, 2)];
        return r;
    endfunction

    // One cycle: check state against the occupancy model at negedge, drive inputs, update the model.
    task automatic cyc(input bit iv, input logic [31:0] inst, input logic [31:0] pc,
                       input bit ordy, input bit fl);
        txn_t t;
        bit   acc;
        @(negedge clk);
        chk("out_valid_m0", 128'(out_valid0), 128'(q.size() != 0));
        chk("in_ready_m0",  128'(in_ready0),  128'(q.size() < 2));
        chk("out_valid_m1", 128'(out_valid1), 128'(q.size() != 0));
        chk("in_ready_m1",  128'(in_ready1),  128'(q.size() < 2));
        acc = iv && (q.size() < 2) && !fl;
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
        if (ordy && q.size() != 0) begin
            t = q.pop_front();
            chk("bundle_m0", 128'(obs0), 128'(ref_dec(t.inst, t.pc, 1'b0)));
            chk("bundle_m1", 128'(obs1), 128'(ref_dec(t.inst, t.pc, 1'b1)));
        end
        if (fl) q.delete();
        else if (acc) q.push_back('{inst, pc});
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        #12;
        chk("rst_bundle", 128'(obs0), 128'(0));
        chk("rst_out_valid", 128'(out_valid0), 128'(0));
        chk("rst_in_ready", 128'(in_ready0), 128'(1));
        @(negedge clk);
        rstn = 1'b1;

        // addi x1,x2,-1
        cyc(1, 32'hFFF10093, 32'h100, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("addi_valid", 128'(out_valid0), 128'(1));
        chk("addi_rs1", 128'(rs1_0), 128'(2));
        chk("addi_rd", 128'(rd0), 128'(1));
        chk("addi_imm", 128'(imm0), 128'(32'hFFFFFFFF));
        chk("addi_op", 128'(op0), 128'(ALU_ADD));
        chk("addi_o2", 128'(o2_0), 128'(OP2_IMM));
        chk("addi_wren", 128'(rw0), 128'(1));
        chk("addi_ill", 128'(ill0), 128'(0));

        // lui x5,0x12345 then lw x6,8(x5)
        cyc(1, 32'h123452B7, 32'h200, 1, 0);
        cyc(1, 32'h0082A303, 32'h204, 1, 0);
        chk("lui_imm", 128'(imm0), 128'(32'h12345000));
        chk("lui_pc", 128'(pc0), 128'(32'h200));
        cyc(0, 0, 0, 1, 0);
        chk("lw_imm", 128'(imm0), 128'(8));
        chk("lw_wsrc", 128'(ws0), 128'(WDATA_RAM));
        chk("lw_funct3", 128'(f3_0), 128'(3'b010));
        chk("lw_pc", 128'(pc0), 128'(32'h204));

        // stall with three offered beats
        cyc(1, 32'h00308113, 32'h300, 0, 0);
        cyc(1, 32'h00408193, 32'h304, 0, 0);
        cyc(1, 32'h00508213, 32'h308, 0, 0);
        chk("stall_in_ready", 128'(in_ready0), 128'(0));
        cyc(1, 32'h00508213, 32'h308, 0, 0);
        cyc(1, 32'h00508213, 32'h308, 1, 0);
        cyc(1, 32'h00508213, 32'h308, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // illegal encodings then a normal addi
        cyc(1, 32'h00000000, 32'h400, 1, 0);
        cyc(1, 32'h0000707F, 32'h404, 1, 0);
        chk("ill0_flag", 128'(ill0), 128'(1));
        chk("ill0_wren", 128'(rw0), 128'(0));
        chk("ill0_ram", 128'(mw0), 128'(0));
        cyc(1, 32'hFFF10093, 32'h408, 1, 0);
        chk("ill7f_flag", 128'(ill0), 128'(1));
        cyc(0, 0, 0, 1, 0);
        chk("post_ill_flag", 128'(ill0), 128'(0));
        chk("post_ill_wren", 128'(rw0), 128'(1));

        // flush with output stalled and skid full, then flush with a beat offered
        cyc(1, 32'h00308113, 32'h500, 0, 0);
        cyc(1, 32'h00408193, 32'h504, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 32'h00508213, 32'h508, 1, 1);
        chk("flush_out_valid", 128'(out_valid0), 128'(0));
        chk("flush_in_ready", 128'(in_ready0), 128'(1));
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("flush_drop", 128'(out_valid0), 128'(0));

        // mul x3,x1,x2 on both configurations, then addi x0,x0,1
        cyc(1, 32'h022081B3, 32'h600, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("mul_m0_ill", 128'(ill0), 128'(1));
        chk("mul_m1_ill", 128'(ill1), 128'(0));
        chk("mul_m1_op", 128'(op1), 128'(ALU_MUL));
        chk("mul_m1_rd", 128'(rd1), 128'(3));
        chk("mul_m1_wren", 128'(rw1), 128'(1));
        cyc(1, 32'h00100013, 32'h604, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("x0_wren", 128'(rw0), 128'(0));
        chk("x0_ill", 128'(ill0), 128'(0));

        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 3) != 0, rand_inst(), 32'h1000 + 32'(n) * 4,
                $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        // asynchronous reset in the middle of a stall
        cyc(1, 32'h00308113, 32'h700, 0, 0);
        cyc(1, 32'h00408193, 32'h704, 0, 0);
        cyc(0, 0, 0, 0, 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_bundle_m0", 128'(obs0), 128'(0));
        chk("arst_bundle_m1", 128'(obs1), 128'(0));
        chk("arst_out_valid", 128'(out_valid0), 128'(0));
        chk("arst_in_ready", 128'(in_ready0), 128'(1));
        q.delete();
        @(negedge clk);
        rstn = 1'b1;
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
